// File: rtl/hazard_suspend_unit.sv
// hazard_suspend_unit: RAW interlock comparing ID sources against EX/MEM/WB destination slots.
// Define SUSPEND_STAT_EN to add a saturating stall-cycle counter on stall_cnt_o.
module hazard_suspend_unit #(
   parameter bit WB_BYPASS = 1'b0
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        id_valid_i,
   input  logic [4:0]  id_rs1_i,
   input  logic [4:0]  id_rs2_i,
   input  logic        id_rs1_used_i,
   input  logic        id_rs2_used_i,
   input  logic [4:0]  id_rd_i,
   input  logic        id_we_i,
   input  logic        flush_i,
   output logic        stall_o,
   output logic        bubble_o,
`ifdef SUSPEND_STAT_EN
   output logic [2:0]  pend_o,
   output logic [31:0] stall_cnt_o
`else
   output logic [2:0]  pend_o
`endif
);
   logic [2:0] slot_v, slot_we, live;
   logic [4:0] slot_rd [3];
   logic       hit1, hit2, hazard;
   // bit0=EX, bit1=MEM, bit2=WB; a write-through regfile makes the WB slot harmless
   assign live   = slot_v & slot_we & {~WB_BYPASS, 2'b11};
   assign pend_o = slot_v & slot_we;
   always_comb begin
      hit1 = 1'b0;
      hit2 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         hit1 = hit1 | (live[i] && slot_rd[i] != 5'd0 && slot_rd[i] == id_rs1_i);
         hit2 = hit2 | (live[i] && slot_rd[i] != 5'd0 && slot_rd[i] == id_rs2_i);
      end
      hazard   = id_valid_i & ~flush_i &
                 ((id_rs1_used_i & (id_rs1_i != 5'd0) & hit1) |
                  (id_rs2_used_i & (id_rs2_i != 5'd0) & hit2));
      stall_o  = hazard & ~reset_i;
      bubble_o = (hazard | flush_i) & ~reset_i;
   end
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         slot_v  <= '0;
         slot_we <= '0;
         slot_rd <= '{default: '0};
      end else begin
         slot_v     <= {slot_v[1:0],  id_valid_i & ~bubble_o};
         slot_we    <= {slot_we[1:0], id_we_i & ~bubble_o};
         slot_rd[2] <= slot_rd[1];
         slot_rd[1] <= slot_rd[0];
         slot_rd[0] <= bubble_o ? 5'd0 : id_rd_i;
      end
   end
`ifdef SUSPEND_STAT_EN
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i)
         stall_cnt_o <= '0;
      else if (stall_o && stall_cnt_o != 32'hFFFF_FFFF)
         stall_cnt_o <= stall_cnt_o + 32'd1;
   end
`endif
endmodule

// File: doc/hazard_suspend_unit.md
HAZARD_SUSPEND_UNIT -- requirements
Module: hazard_suspend_unit

Interface
REQ-001 SHALL have parameter WB_BYPASS, default 0; when 1 the register file is write-through, and the WB-stage slot is excluded from hazard compares.
REQ-002 SHALL have port clk_i, input, 1 bit: the single clock. All state updates on its rising edge.
REQ-003 SHALL have port reset_i, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port id_valid_i, input, 1 bit: the decode stage holds a real instruction.
REQ-005 SHALL have ports id_rs1_i and id_rs2_i, input, 5 bits each: source register fields, i.e. inst[19:15] and inst[24:20].
REQ-006 SHALL have ports id_rs1_used_i and id_rs2_used_i, input, 1 bit each: the decoded instruction reads that source.
REQ-007 SHALL have port id_rd_i, input, 5 bits: destination field inst[11:7].
REQ-008 SHALL have port id_we_i, input, 1 bit: the decoded instruction writes rd.
REQ-009 SHALL have port flush_i, input, 1 bit: a taken branch/jump resolved in EX; squash ID.
REQ-010 SHALL have port stall_o, output, 1 bit: hold the PC and the IF/ID register.
REQ-011 SHALL have port bubble_o, output, 1 bit: load a NOP (we=0) into the ID/EX register.
REQ-012 SHALL have port pend_o, output, 3 bits: valid write bits of slots {WB,MEM,EX}.

Function
REQ-013 SHALL keep three slots EX, MEM, WB, each holding {valid, rd[4:0], we}.
REQ-014 SHALL compute hazard combinationally: id_valid_i & ~flush_i & (rsN_used & rsN!=0 & rsN matches the rd of any slot with valid&we), for N=1,2; the WB slot is included only when WB_BYPASS=0.
REQ-015 SHALL drive stall_o = hazard and bubble_o = hazard | flush_i, combinationally, with no added latency.
REQ-016 SHALL shift slots every cycle (MEM<=EX, WB<=MEM); the pipeline never freezes downstream of ID.
REQ-017 SHALL load EX with {id_valid_i, id_rd_i, id_we_i} when bubble_o=0, and with {0,0,0} when bubble_o=1.
REQ-018 SHALL treat rd=0 writes as non-hazardous: a slot whose rd=0 never matches.
REQ-019 SHALL bound a stall to at most 3 cycles (2 when WB_BYPASS=1) for a single producer; back-to-back dependencies stall again after release.
REQ-020 SHALL give flush_i priority over hazard when both are active: stall_o=0, bubble_o=1.
REQ-021 SHALL ignore source fields when id_valid_i=0: stall_o=0, and EX is loaded invalid.
REQ-022 SHALL set pend_o[i] = valid&we of each slot, with bit0=EX, bit1=MEM, bit2=WB.

Reset
REQ-023 SHALL, while reset_i=1, asynchronously clear all slots to {0,0,0}; stall_o=0, bubble_o=0, pend_o=0.
REQ-024 SHALL treat reset asserted mid-stall as aborting the stall immediately; the first cycle after release SHALL show stall_o=0 unless new ID inputs create a hazard.

Configuration
REQ-025 SHALL support macro SUSPEND_STAT_EN. When defined, it adds output stall_cnt_o, 32 bits, counting cycles with stall_o=1. The counter saturates at 32'hFFFFFFFF and is cleared by reset_i. When undefined, the port and counter are absent and the remaining behaviour is identical.

Verification
REQ-026 SHALL test this case: addi x5 (rd=5, we=1) then add x6,x5,x1 next cycle, WB_BYPASS=0 -> stall_o=1 for 3 cycles, bubble_o=1 for those 3, and the add enters EX on cycle 4.
REQ-027 SHALL test the same sequence with WB_BYPASS=1 -> stall_o=1 for exactly 2 cycles.
REQ-028 SHALL test this case: producer rd=0 followed by a consumer of rs1=0 -> stall_o never asserts and pend_o[0]=1 for one cycle.
REQ-029 SHALL test this case: hazard active and flush_i=1 in the same cycle -> stall_o=0, bubble_o=1, and EX slot is invalid next cycle.
REQ-030 SHALL test this case: reset_i pulsed during the 2nd stall cycle -> pend_o=0 and stall_o=0 without waiting for a clock edge.
REQ-031 SHALL test, with SUSPEND_STAT_EN defined, two independent 3-cycle stalls -> stall_cnt_o=6.
